lfsr_hv_sequencer: RTL and testbench

- Shared item-memory hypervector generator for the HDC encoder.
- Arbitrates round-robin between NUM_REQ requesters, each asking for the hypervector of an item ID (channel/level index).
- Reseeds one embedded LFSR per request and clocks it to produce DIM bits.
- Streams the result as DIM/CHUNK words over a valid/ready interface, tagged with the owning requester.

---
 rtl/hdc_lfsr_pkg.sv | 29 ++
 rtl/lfsr_core.sv | 34 +++
 rtl/lfsr_hv_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_lfsr_hv_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdc_lfsr_pkg.sv
// Shared types, constants and the seed-mixing helper for the item-memory
// hypervector sequencer.
package hdc_lfsr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WARM,
    GEN,
    OUT
  } state_t;

  localparam logic [31:0] DEFAULT_SEED      = 32'hee84d6f0;
  localparam logic [31:0] DEFAULT_ITEM_MULT = 32'h9E3779B9;

  // Feedback taps of the right-shifting LFSR (new MSB = xor of these bits)
  localparam int TAP_A = 0;
  localparam int TAP_B = 2;
  localparam int TAP_C = 6;
  localparam int TAP_D = 7;

  // Spread item IDs across the seed space; the caller truncates to the LFSR length
  function automatic logic [63:0] seed_mix(input logic [63:0] base,
                                           input logic [63:0] mult,
                                           input logic [63:0] item);
    return base ^ (mult * item);
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR shifting right, with synchronous seed load and step enable.
// The serial output bit is regs[0].
module lfsr_core
  import hdc_lfsr_pkg::*;
#(
  parameter int                  NUM_REGS = 32,
  parameter logic [NUM_REGS-1:0] SEED     = NUM_REGS'(DEFAULT_SEED)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [NUM_REGS-1:0] seed_in,
  input  logic                step,
  output logic                out_bit
);

  logic [NUM_REGS-1:0] regs;
  logic                fb;

  assign fb      = regs[TAP_A] ^ regs[TAP_B] ^ regs[TAP_C] ^ regs[TAP_D];
  assign out_bit = regs[0];

  // Load has priority over stepping; the register holds otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= SEED;
    end else if (load) begin
      regs <= seed_in;
    end else if (step) begin
      regs <= {fb, regs[NUM_REGS-1:1]};
    end
  end

endmodule

// File: rtl/lfsr_hv_sequencer.sv
// Shared item-memory hypervector generator: round-robin arbitration between
// requesters, one LFSR reseeded per request, DIM bits streamed as CHUNK-bit
// words tagged with the owning requester.
// Optional build macro LFSR_WARMUP_EN inserts a WARM state that discards
// WARMUP_CYCLES LFSR bits after each seed load.
module lfsr_hv_sequencer
  import hdc_lfsr_pkg::*;
#(
`ifdef LFSR_WARMUP_EN
  parameter int                  WARMUP_CYCLES = 32,
`endif
  parameter int                  NUM_REQ   = 4,
  parameter int                  ID_W      = 8,
  parameter int                  DIM       = 1024,
  parameter int                  CHUNK     = 32,
  parameter int                  NUM_REGS  = 32,
  parameter logic [NUM_REGS-1:0] SEED      = NUM_REGS'(DEFAULT_SEED),
  parameter logic [NUM_REGS-1:0] ITEM_MULT = NUM_REGS'(DEFAULT_ITEM_MULT)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*ID_W-1:0]      req_item,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHUNK-1:0]             out_data,
  output logic [$clog2(DIM/CHUNK)-1:0] out_idx,
  output logic                         out_last,
  output logic [$clog2(NUM_REQ)-1:0]   out_owner,
  output logic                         busy
);

  localparam int WORDS = DIM / CHUNK;
  localparam int IDX_W = $clog2(WORDS);
  localparam int OWN_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(CHUNK);

  state_t              state, state_nxt;
  logic [OWN_W-1:0]    rr_ptr, grant, owner;
  logic                grant_vld;
  logic [ID_W-1:0]     items [NUM_REQ];
  logic [ID_W-1:0]     item;
  logic [CNT_W-1:0]    bitcnt;
  logic [IDX_W-1:0]    wordcnt;
  logic [CHUNK-1:0]    word;
  logic [NUM_REGS-1:0] seed_raw, seed_load;
  logic                lfsr_load, lfsr_step, lfsr_bit;
  int                  cand;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_items
    assign items[g] = req_item[g*ID_W +: ID_W];
  end

  // An all-zero seed would lock the LFSR, so fall back to the base seed
  assign seed_raw  = NUM_REGS'(seed_mix(64'(SEED), 64'(ITEM_MULT), 64'(item)));
  assign seed_load = (seed_raw == '0) ? SEED : seed_raw;

  assign out_valid = (state == OUT);
  assign out_last  = (state == OUT) && (wordcnt == IDX_W'(WORDS - 1));
  assign out_data  = word;
  assign out_idx   = wordcnt;
  assign out_owner = owner;
  assign busy      = (state != IDLE);

  lfsr_core #(
    .NUM_REGS (NUM_REGS),
    .SEED     (SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (lfsr_load),
    .seed_in (seed_load),
    .step    (lfsr_step),
    .out_bit (lfsr_bit)
  );

`ifdef LFSR_WARMUP_EN
  localparam int WCNT_W = $clog2(WARMUP_CYCLES + 1);
  logic [WCNT_W-1:0] warmcnt;
  logic              warm_done;

  assign warm_done = (warmcnt == WCNT_W'(WARMUP_CYCLES - 1));

  // Count discarded warm-up steps, restarting at every seed load
  always_ff @(posedge clk) begin
    if (rst || state == LOAD) begin
      warmcnt <= '0;
    end else if (state == WARM) begin
      warmcnt <= warmcnt + 1'b1;
    end
  end
`endif

  // Round-robin search: first asserted request at or above rr_ptr, with wrap
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!grant_vld && req_valid[OWN_W'(cand)]) begin
        grant_vld = 1'b1;
        grant     = OWN_W'(cand);
      end
    end
  end

  // Next-state decode plus LFSR control and the one-hot accept
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          req_ready[grant] = 1'b1;
          state_nxt        = LOAD;
        end
      end
      LOAD: begin
        lfsr_load = 1'b1;
`ifdef LFSR_WARMUP_EN
        state_nxt = WARM;
`else
        state_nxt = GEN;
`endif
      end
`ifdef LFSR_WARMUP_EN
      WARM: begin
        lfsr_step = 1'b1;
        if (warm_done) state_nxt = GEN;
      end
`endif
      GEN: begin
        lfsr_step = 1'b1;
        if (bitcnt == CNT_W'(CHUNK - 1)) state_nxt = OUT;
      end
      OUT: begin
        if (out_ready) state_nxt = out_last ? IDLE : GEN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, arbitration pointer, request latch and word assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      owner   <= '0;
      item    <= '0;
      bitcnt  <= '0;
      wordcnt <= '0;
      word    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            owner  <= grant;
            item   <= items[grant];
            rr_ptr <= (grant == OWN_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
          end
        end
        LOAD: begin
          bitcnt  <= '0;
          wordcnt <= '0;
        end
        GEN: begin
          word[bitcnt] <= lfsr_bit;
          bitcnt       <= (bitcnt == CNT_W'(CHUNK - 1)) ? '0 : bitcnt + 1'b1;
        end
        OUT: begin
          if (out_ready && !out_last) wordcnt <= wordcnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_hv_sequencer.sv
// Directed bench for lfsr_hv_sequencer: single vector, round-robin order,
// backpressure, reset mid-vector and the zero-seed guard (second instance
// whose multiplier maps item 1 onto the base seed).
module tb_lfsr_hv_sequencer;

  localparam int          NUM_REQ = 4;
  localparam int          ID_W    = 8;
  localparam int          DIM     = 1024;
  localparam int          CHUNK   = 32;
  localparam int          WORDS   = DIM / CHUNK;
  localparam logic [31:0] SEED    = 32'hee84d6f0;
  localparam logic [31:0] MULT    = 32'h9E3779B9;
  localparam logic [31:0] Z_MULT  = 32'hee84d6f0;
`ifdef LFSR_WARMUP_EN
  localparam int          WARM_N  = 32;
`else
  localparam int          WARM_N  = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_ready;
  logic [31:0] req_item;
  logic        out_valid, out_ready, out_last, busy;
  logic [31:0] out_data;
  logic [4:0]  out_idx;
  logic [1:0]  out_owner;

  logic [3:0]  z_req_valid, z_req_ready;
  logic [31:0] z_req_item;
  logic        z_out_valid, z_out_ready, z_out_last, z_busy;
  logic [31:0] z_out_data;
  logic [4:0]  z_out_idx;
  logic [1:0]  z_out_owner;

  int total = 0;
  int bad   = 0;
  int exp_grants[$];

  // word 0 of items 0..3 without warm-up is SEED ^ (MULT*item), worked by hand
  logic [31:0] hand_w0 [4] = '{32'hee84d6f0, 32'h70b3af49, 32'hd2ea2582, 32'h3422bbdb};

  always #5 clk = ~clk;

  lfsr_hv_sequencer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_item(req_item),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .out_owner(out_owner), .busy(busy)
  );

  lfsr_hv_sequencer #(.ITEM_MULT(Z_MULT)) dut_z (
    .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_item(z_req_item),
    .req_ready(z_req_ready), .out_valid(z_out_valid), .out_ready(z_out_ready),
    .out_data(z_out_data), .out_idx(z_out_idx), .out_last(z_out_last),
    .out_owner(z_out_owner), .busy(z_busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] r);
    return {r[0] ^ r[2] ^ r[6] ^ r[7], r[31:1]};
  endfunction

  function automatic logic [31:0] model_seed(input logic [31:0] mult, input int item);
    logic [31:0] s;
    s = SEED ^ (mult * 32'(item));
    return (s == 32'd0) ? SEED : s;
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] seed, input int k);
    logic [31:0] r, w;
    r = seed;
    w = '0;
    for (int i = 0; i < WARM_N + k * CHUNK; i++) r = lfsr_next(r);
    for (int b = 0; b < CHUNK; b++) begin
      w[b] = r[0];
      r    = lfsr_next(r);
    end
    return w;
  endfunction

  task automatic all_zero(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"},  out_data,  0);
    chk({tag, "_idx"},   out_idx,   0);
    chk({tag, "_last"},  out_last,  0);
    chk({tag, "_owner"}, out_owner, 0);
    chk({tag, "_busy"},  busy,      0);
    chk({tag, "_ready"}, req_ready, 0);
  endtask

  // Drive requests/consumer until nvec vectors finish (or stop_words words move)
  task automatic run_traffic(input int nvec, input bit bp, input int stop_words);
    int          done = 0, words = 0, cyc = 0, lat = 0, gap = 0, ig = 0, m_idx = 0;
    int          cur_item = 0, cur_own = 0, limit;
    bit          lat_on = 0, gap_on = 0, ig_on = 0, hold = 0, stop = 0;
    logic [31:0] seed = '0, h_data = '0;
    logic [4:0]  h_idx = '0;
    logic [1:0]  h_own = '0;
    logic [3:0]  s_rdy;
    limit = nvec * (WORDS * (CHUNK + 12) + WARM_N + 16) + 64;
    while (!stop && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (lat_on) lat++;
      if (gap_on) gap++;
      if (ig_on)  ig++;
      s_rdy = req_ready;
      if (busy) chk("ready_while_busy", s_rdy, 0);
      if (s_rdy != 4'd0) begin
        chk("ready_onehot", $countones(s_rdy), 1);
        for (int i = 0; i < NUM_REQ; i++) if (s_rdy[i]) cur_own = i;
        if (exp_grants.size() > 0) chk("grant_order", cur_own, exp_grants.pop_front());
        if (ig_on) begin
          chk("regrant_gap", ig, 1);
          ig_on = 0;
        end
        cur_item = int'(req_item[cur_own*ID_W +: ID_W]);
        seed     = model_seed(MULT, cur_item);
        m_idx    = 0;
        lat      = 0;
        lat_on   = 1;
      end
      if (hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data",  out_data,  h_data);
        chk("hold_idx",   out_idx,   h_idx);
        chk("hold_owner", out_owner, h_own);
      end
      if (out_valid && lat_on) begin
        chk("first_latency", lat, CHUNK + 2 + WARM_N);
        lat_on = 0;
      end
      if (out_valid && gap_on) begin
        chk("word_gap", gap, CHUNK + 1);
        gap_on = 0;
      end
      if (out_valid && out_ready) begin
        chk("word_data",  out_data,  model_word(seed, m_idx));
        chk("word_idx",   out_idx,   m_idx);
        chk("word_last",  out_last,  m_idx == WORDS - 1);
        chk("word_owner", out_owner, cur_own);
`ifndef LFSR_WARMUP_EN
        if (m_idx == 0 && cur_item < 4) chk("word0_hand", out_data, hand_w0[cur_item]);
`endif
        words++;
        m_idx++;
        if (out_last) begin
          done++;
          if (req_valid != 4'd0) begin
            ig    = 0;
            ig_on = 1;
          end
        end else begin
          gap    = 0;
          gap_on = 1;
        end
        if (stop_words > 0 && words == stop_words) stop = 1;
      end
      hold   = out_valid && !out_ready;
      h_data = out_data;
      h_idx  = out_idx;
      h_own  = out_owner;
      if (done == nvec) stop = 1;
      @(posedge clk);
      #1;
      req_valid = req_valid & ~s_rdy;
      if (bp) out_ready = 1'($urandom_range(0, 1));
    end
    if (stop_words == 0) chk("vectors_done", done, nvec);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    bit found;
    rst = 1'b1;
    req_valid = '0;  req_item = '0;  out_ready = 1'b1;
    z_req_valid = '0; z_req_item = '0; z_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    all_zero("reset");
    @(posedge clk);
    #1;

    // single vector: requester 0, item 0
    req_item  = 32'h0000_0000;
    req_valid = 4'b0001;
    exp_grants.push_back(0);
    run_traffic(1, 1'b0, 0);

    // round-robin from a fresh pointer: all four requesters, then 0 and 2
    pulse_reset();
    req_item  = 32'h0302_0100;
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) exp_grants.push_back(i);
    run_traffic(4, 1'b0, 0);
    req_item  = 32'h00C8_0005;
    req_valid = 4'b0101;
    exp_grants.push_back(0);
    exp_grants.push_back(2);
    run_traffic(2, 1'b0, 0);

    // random backpressure; pointer sits at 3 so requester 3 wins first
    req_item  = 32'h0300_0900;
    req_valid = 4'b1010;
    exp_grants.push_back(3);
    exp_grants.push_back(1);
    run_traffic(2, 1'b1, 0);
    out_ready = 1'b1;

    // reset while generating word 5, then the same item again
    req_item  = 32'h0000_0000;
    req_valid = 4'b0001;
    exp_grants.push_back(0);
    run_traffic(1, 1'b0, 5);
    repeat (2) @(posedge clk);
    #1;
    pulse_reset();
    @(negedge clk);
    all_zero("midreset");
    @(posedge clk);
    #1;
    req_valid = 4'b0001;
    exp_grants.push_back(0);
    run_traffic(1, 1'b0, 0);

    // zero-seed guard on the second instance: item 1 derives seed 0
    z_req_item  = 32'h0000_0001;
    z_req_valid = 4'b0001;
    found = 1'b0;
    for (int c = 0; c < CHUNK + WARM_N + 20 && !found; c++) begin
      @(negedge clk);
      if (z_out_valid) begin
        found = 1'b1;
        chk("zero_guard_word0", z_out_data, model_word(model_seed(Z_MULT, 1), 0));
`ifndef LFSR_WARMUP_EN
        chk("zero_guard_hand", z_out_data, 32'hee84d6f0);
`endif
        chk("zero_guard_idx",   z_out_idx,   0);
        chk("zero_guard_owner", z_out_owner, 0);
        chk("zero_guard_last",  z_out_last,  0);
        chk("zero_guard_busy",  z_busy,      1);
      end
      if (z_req_ready[0]) begin
        @(posedge clk);
        #1 z_req_valid = '0;
      end
    end
    chk("zero_guard_seen", found, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
